// File: rtl/fp_sum_initiator_pkg.sv
// Shared definitions for the FP sum initiator: word format constants and the
// state encoding of its control FSM.
package fp_sum_initiator_pkg;

  localparam int              FP_W        = 32;
  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IN   = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_OUT       = 3'd4
  } state_e;

endpackage

// File: rtl/fp_sum_initiator_watchdog.sv
// Cycle watchdog for an outstanding adder request: counts while enabled and
// flags expiry once TIMEOUT-1 cycles have elapsed since the last clear.
module fp_sum_initiator_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up and saturate at the expiry value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (count_en && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/fp_sum_initiator.sv
// Streams N single-precision words through an external enable/done adder,
// accumulating the running sum, and emits one sum (or a timeout error) per job.
module fp_sum_initiator
  import fp_sum_initiator_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  input  logic [FP_W-1:0]  in_data,
  output logic             in_ready,
  output logic             fpu_enable,
  output logic [FP_W-1:0]  fpu_dataa,
  output logic [FP_W-1:0]  fpu_datab,
  input  logic [FP_W-1:0]  fpu_result,
  input  logic             fpu_done,
  output logic             sum_valid,
  output logic [FP_W-1:0]  sum_data,
  output logic             error
);

  state_e            state_q,      state_d;
  logic              busy_q,       busy_d;
  logic              in_ready_q,   in_ready_d;
  logic              fpu_enable_q, fpu_enable_d;
  logic [FP_W-1:0]   dataa_q,      dataa_d;
  logic [FP_W-1:0]   datab_q,      datab_d;
  logic [FP_W-1:0]   acc_q,        acc_d;
  logic [LEN_W-1:0]  rem_q,        rem_d;
  logic              error_q,      error_d;
  logic              sum_valid_q,  sum_valid_d;
  logic [FP_W-1:0]   sum_data_q,   sum_data_d;
  logic              wd_clear;
  logic              wd_count;
  logic              wd_expired;

  fp_sum_initiator_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (wd_clear),
    .count_en (wd_count),
    .expired  (wd_expired)
  );

  // Next-state and datapath decode for the job FSM.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    fpu_enable_d = fpu_enable_q;
    dataa_d      = dataa_q;
    datab_d      = datab_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    error_d      = error_q;
    sum_valid_d  = 1'b0;
    sum_data_d   = sum_data_q;
    wd_clear     = 1'b0;
    wd_count     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // busy still high here means this is the sum_valid/error cycle.
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start) begin
          busy_d  = 1'b1;
          rem_d   = len;
          acc_d   = FP_POS_ZERO;
          error_d = 1'b0;
          state_d = (len == {LEN_W{1'b0}}) ? ST_OUT : ST_WAIT_IN;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          datab_d      = in_data;
          dataa_d      = acc_q;
          fpu_enable_d = 1'b1;
          wd_clear     = 1'b1;
          state_d      = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_IN;
        end
      end
      ST_WAIT_DONE: begin
        if (fpu_done) begin
          acc_d        = fpu_result;
          fpu_enable_d = 1'b0;
          rem_d        = rem_q - LEN_W'(1);
          state_d      = ST_RELEASE;
        end else if (wd_expired) begin
          fpu_enable_d = 1'b0;
          error_d      = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          wd_count = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!fpu_done) begin
          state_d = (rem_q == {LEN_W{1'b0}}) ? ST_OUT : ST_WAIT_IN;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_OUT: begin
        sum_valid_d = 1'b1;
        sum_data_d  = acc_q;
        state_d     = ST_IDLE;
      end
      default: begin
        fpu_enable_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_WAIT_IN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      fpu_enable_q <= 1'b0;
      dataa_q      <= FP_POS_ZERO;
      datab_q      <= FP_POS_ZERO;
      acc_q        <= FP_POS_ZERO;
      rem_q        <= {LEN_W{1'b0}};
      error_q      <= 1'b0;
      sum_valid_q  <= 1'b0;
      sum_data_q   <= FP_POS_ZERO;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      fpu_enable_q <= fpu_enable_d;
      dataa_q      <= dataa_d;
      datab_q      <= datab_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      error_q      <= error_d;
      sum_valid_q  <= sum_valid_d;
      sum_data_q   <= sum_data_d;
    end
  end

  assign busy       = busy_q;
  assign in_ready   = in_ready_q;
  assign fpu_enable = fpu_enable_q;
  assign fpu_dataa  = dataa_q;
  assign fpu_datab  = datab_q;
  assign sum_valid  = sum_valid_q;
  assign sum_data   = sum_data_q;
  assign error      = error_q;

endmodule

// File: tb/tb_fp_sum_initiator.sv
// Scoreboard bench for fp_sum_initiator with a behavioural enable/done adder
// whose latency, done hold time and hang behaviour are set per scenario.
module tb_fp_sum_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        fpu_enable;
  logic [31:0] fpu_dataa;
  logic [31:0] fpu_datab;
  logic [31:0] fpu_result;
  logic        fpu_done;
  logic        sum_valid;
  logic [31:0] sum_data;
  logic        error;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];

  // adder model configuration
  int   lat        = 1;
  int   hold_cyc   = 0;
  logic never_done = 1'b0;
  int   m_cnt;
  int   m_hold;

  // bus probes
  int          en_high   = 0;
  int          en_rises  = 0;
  int          ovl_viol  = 0;
  int          stab_viol = 0;
  logic        prev_en   = 1'b0;
  logic [31:0] prev_a    = 32'h0;
  logic [31:0] prev_b    = 32'h0;

  fp_sum_initiator #(.LEN_W(8), .TIMEOUT(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fpu_enable (fpu_enable),
    .fpu_dataa  (fpu_dataa),
    .fpu_datab  (fpu_datab),
    .fpu_result (fpu_result),
    .fpu_done   (fpu_done),
    .sum_valid  (sum_valid),
    .sum_data   (sum_data),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed IEEE-754 sums for the operand pairs the scenarios use.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] k;
    k = {a, b};
    case (k)
      {32'h0000_0000, 32'h3F80_0000}: return 32'h3F80_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4040_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {32'h0000_0000, 32'h40A0_0000}: return 32'h40A0_0000;
      {32'h40A0_0000, 32'hC0A0_0000}: return 32'h0000_0000;
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      default:                        return 32'h7FC0_0000;
    endcase
  endfunction

  // Behavioural adder: done after lat enabled edges, cleared hold_cyc edges after enable drops.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpu_done   <= 1'b0;
      fpu_result <= 32'h0;
      m_cnt      <= 0;
      m_hold     <= 0;
    end else if (fpu_enable) begin
      m_hold <= 0;
      if (!fpu_done && !never_done) begin
        if (m_cnt >= lat - 1) begin
          fpu_done   <= 1'b1;
          fpu_result <= fadd(fpu_dataa, fpu_datab);
          m_cnt      <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else begin
      m_cnt <= 0;
      if (fpu_done) begin
        if (m_hold >= hold_cyc) begin
          fpu_done <= 1'b0;
          m_hold   <= 0;
        end else begin
          m_hold <= m_hold + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  // Scoreboard monitor: every sum_valid pulse pops one expected sum.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && sum_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_sum: got %h, expected no sum_valid", sum_data);
        end else begin
          chk("sum_data", sum_data, exp_q.pop_front());
          chk("busy_in_sum_cycle", busy, 1'b1);
        end
      end
    end
  end

  // Bus probe: enable-high cycles, request starts, overlap and operand stability.
  initial begin
    forever begin
      @(negedge clk);
      if (fpu_enable === 1'b1) en_high++;
      if (fpu_enable === 1'b1 && !prev_en) begin
        en_rises++;
        if (fpu_done === 1'b1) ovl_viol++;
      end
      if (fpu_enable === 1'b1 && prev_en && (fpu_dataa !== prev_a || fpu_datab !== prev_b))
        stab_viol++;
      prev_en = fpu_enable;
      prev_a  = fpu_dataa;
      prev_b  = fpu_datab;
    end
  end

  task automatic start_job(input int l, output int at_cyc);
    @(negedge clk);
    start = 1'b1;
    len   = l[7:0];
    @(posedge clk);
    #1;
    at_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic send(input logic [31:0] w, input int gap, output int at_cyc);
    int t = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, expected high", t);
    end
    @(posedge clk);
    #1;
    at_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic wait_sum(output int at_cyc);
    int t = 0;
    in_valid = 1'b0;
    while (sum_valid !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sum_valid !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sum_timeout: no sum_valid after %0d cycles, expected a pulse", t);
    end
    at_cyc = cyc;
    @(negedge clk);
    chk("busy_after_sum", busy, 1'b0);
    chk("sum_valid_one_cycle", sum_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int c_start, c_a0, c_a, c_sum, r0, h0, t;

    reset_n  = 1'b0;
    start    = 1'b0;
    len      = 8'd0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_in_ready",   in_ready,   1'b0);
    chk("rst_fpu_enable", fpu_enable, 1'b0);
    chk("rst_sum_valid",  sum_valid,  1'b0);
    chk("rst_error",      error,      1'b0);
    chk("rst_dataa",      fpu_dataa,  32'h0);
    chk("rst_datab",      fpu_datab,  32'h0);
    chk("rst_sum_data",   sum_data,   32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: 1.0 + 2.0 + 3.0 back-to-back, 5 cycles per element
    exp_q.push_back(32'h40C0_0000);
    start_job(3, c_start);
    send(32'h3F80_0000, 0, c_a0);
    send(32'h4000_0000, 0, c_a);
    chk("t1_accept_spacing", c_a - c_a0, 5);
    send(32'h4040_0000, 0, c_a);
    wait_sum(c_sum);
    chk("t1_accept_to_sum", c_sum - c_a0, 15);

    // 2: empty job
    r0 = en_rises;
    exp_q.push_back(32'h0000_0000);
    start_job(0, c_start);
    wait_sum(c_sum);
    chk("t2_start_to_sum", c_sum - c_start, 1);
    chk("t2_no_enable", en_rises - r0, 0);

    // 3: 5.0 + -5.0 with an input gap and an ignored start mid-job
    r0 = en_rises;
    exp_q.push_back(32'h0000_0000);
    start_job(2, c_start);
    send(32'h40A0_0000, 0, c_a0);
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    send(32'hC0A0_0000, 6, c_a);
    wait_sum(c_sum);
    chk("t3_ops_issued", en_rises - r0, 2);
    chk("t3_operand_stability", stab_viol, 0);

    // 4: adder hangs, watchdog aborts; then a clean len=1 job
    never_done = 1'b1;
    start_job(1, c_start);
    h0 = en_high;
    send(32'h3F80_0000, 0, c_a0);
    in_valid = 1'b0;
    t = 0;
    while (error !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t4_error_set", error, 1'b1);
    chk("t4_enable_dropped", fpu_enable, 1'b0);
    chk("t4_enable_high_cycles", en_high - h0, 64);
    chk("t4_busy_in_error_cycle", busy, 1'b1);
    @(negedge clk);
    chk("t4_busy_after_error", busy, 1'b0);
    chk("t4_error_sticky", error, 1'b1);
    never_done = 1'b0;
    exp_q.push_back(32'h3F80_0000);
    start_job(1, c_start);
    chk("t4_error_cleared", error, 1'b0);
    send(32'h3F80_0000, 0, c_a0);
    wait_sum(c_sum);

    // 5: slow adder holding done after enable drops
    lat      = 4;
    hold_cyc = 2;
    r0 = en_rises;
    exp_q.push_back(32'h4000_0000);
    start_job(2, c_start);
    send(32'h3F80_0000, 0, c_a0);
    send(32'h3F80_0000, 0, c_a);
    wait_sum(c_sum);
    chk("t5_ops_issued", en_rises - r0, 2);
    chk("t5_no_overlap", ovl_viol, 0);

    // 6: reset while waiting for the adder, then a normal job
    start_job(1, c_start);
    send(32'h3F80_0000, 0, c_a0);
    in_valid = 1'b0;
    chk("t6_in_wait_done", fpu_enable, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_enable", fpu_enable, 1'b0);
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_in_ready", in_ready, 1'b0);
    @(negedge clk);
    reset_n  = 1'b1;
    lat      = 1;
    hold_cyc = 0;
    exp_q.push_back(32'h3F80_0000);
    start_job(1, c_start);
    send(32'h3F80_0000, 0, c_a0);
    wait_sum(c_sum);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("operand_stability_all", stab_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
